// File: rtl/current_pi_regulator.sv
// rtl/current_pi_regulator.sv - dual d/q-axis PI current regulator with one shared multiplier
// Four products per update (err_d*kp, err_d*ki, err_q*kp, err_q*ki), clamped integrators for anti-windup.
module current_pi_regulator #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_FRAC  = 12
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         calc_enable_in,
  input  logic                         integ_clear_in,
  input  logic signed [DATA_WIDTH-1:0] current_d_ref_in,
  input  logic signed [DATA_WIDTH-1:0] current_q_ref_in,
  input  logic signed [DATA_WIDTH-1:0] current_d_in,
  input  logic signed [DATA_WIDTH-1:0] current_q_in,
  input  logic signed [DATA_WIDTH-1:0] sin_in,
  input  logic signed [DATA_WIDTH-1:0] cos_in,
  input  logic signed [DATA_WIDTH-1:0] kp_in,
  input  logic signed [DATA_WIDTH-1:0] ki_in,
  input  logic        [DATA_WIDTH-1:0] output_limit_in,
  output logic signed [DATA_WIDTH-1:0] voltage_d_out,
  output logic signed [DATA_WIDTH-1:0] voltage_q_out,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic                         regulation_valid_out,
  output logic                         busy_out
);

  localparam int DW = DATA_WIDTH;
  localparam int EW = DW + 1;
  localparam int PW = EW + DW;
  localparam int SW = PW - GAIN_FRAC;
  localparam int AW = SW + 1;

  typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           mult_cnt_q, mult_cnt_d;
  logic signed [EW-1:0] d_err_q, d_err_d, q_err_q, q_err_d;
  logic signed [DW-1:0] kp_q, kp_d, ki_q, ki_d;
  logic        [DW-1:0] lim_q, lim_d;
  logic signed [DW-1:0] sin_q, sin_d, cos_q, cos_d;
  logic signed [DW-1:0] d_integ_q, d_integ_d, q_integ_q, q_integ_d;
  logic signed [DW-1:0] d_volt_q, d_volt_d, q_volt_q, q_volt_d;
  logic                 valid_q, valid_d;
  // prod index: 0 = p_d, 1 = i_d, 2 = p_q, 3 = i_q (matches mult_cnt order)
  logic signed [SW-1:0] prod_q [4];
  logic signed [SW-1:0] prod_d [4];

  logic signed [EW-1:0] mult_a;
  logic signed [DW-1:0] mult_b;
  logic signed [PW-1:0] prod_full;
  logic signed [SW-1:0] prod_shift;
  logic signed [AW-1:0] d_integ_sum, q_integ_sum, d_volt_sum, q_volt_sum;
  logic signed [DW-1:0] d_integ_new, q_integ_new;

  function automatic logic signed [DW-1:0] clamp_sym(input logic signed [AW-1:0] x,
                                                     input logic        [DW-1:0] lim);
    logic signed [AW-1:0] hi;
    logic signed [AW-1:0] res;
    hi = $signed(AW'(lim));
    if (x > hi)       res = hi;
    else if (x < -hi) res = -hi;
    else              res = x;
    return DW'(res);
  endfunction

  always_comb begin
    mult_a      = mult_cnt_q[1] ? q_err_q : d_err_q;
    mult_b      = mult_cnt_q[0] ? ki_q : kp_q;
    prod_full   = PW'(mult_a) * PW'(mult_b);
    // arithmetic shift floors toward negative infinity
    prod_shift  = SW'(prod_full >>> GAIN_FRAC);
    d_integ_sum = AW'(d_integ_q) + AW'(prod_q[1]);
    q_integ_sum = AW'(q_integ_q) + AW'(prod_q[3]);
    d_integ_new = clamp_sym(d_integ_sum, lim_q);
    q_integ_new = clamp_sym(q_integ_sum, lim_q);
    d_volt_sum  = AW'(prod_q[0]) + AW'(d_integ_new);
    q_volt_sum  = AW'(prod_q[2]) + AW'(q_integ_new);
  end

  always_comb begin
    state_d    = state_q;
    mult_cnt_d = mult_cnt_q;
    d_err_d    = d_err_q;
    q_err_d    = q_err_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    lim_d      = lim_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    d_integ_d  = d_integ_q;
    q_integ_d  = q_integ_q;
    d_volt_d   = d_volt_q;
    q_volt_d   = q_volt_q;
    valid_d    = 1'b0;
    for (int i = 0; i < 4; i++) prod_d[i] = prod_q[i];

    if (integ_clear_in) begin
      state_d    = IDLE;
      mult_cnt_d = 2'd0;
      d_integ_d  = '0;
      q_integ_d  = '0;
      d_volt_d   = '0;
      q_volt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (calc_enable_in) begin
            state_d    = MULT;
            mult_cnt_d = 2'd0;
            d_err_d    = EW'(current_d_ref_in) - EW'(current_d_in);
            q_err_d    = EW'(current_q_ref_in) - EW'(current_q_in);
            kp_d       = kp_in;
            ki_d       = ki_in;
            lim_d      = output_limit_in[DW-1] ? {1'b0, {(DW-1){1'b1}}} : output_limit_in;
            sin_d      = sin_in;
            cos_d      = cos_in;
          end
        end
        MULT: begin
          prod_d[mult_cnt_q] = prod_shift;
          mult_cnt_d         = mult_cnt_q + 2'd1;
          if (mult_cnt_q == 2'd3) state_d = ACC;
        end
        ACC: begin
          d_integ_d = d_integ_new;
          q_integ_d = q_integ_new;
          d_volt_d  = clamp_sym(d_volt_sum, lim_q);
          q_volt_d  = clamp_sym(q_volt_sum, lim_q);
          state_d   = DONE;
        end
        DONE: begin
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mult_cnt_q <= 2'd0;
      d_err_q    <= '0;
      q_err_q    <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      lim_q      <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
      d_integ_q  <= '0;
      q_integ_q  <= '0;
      d_volt_q   <= '0;
      q_volt_q   <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < 4; i++) prod_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
      d_err_q    <= d_err_d;
      q_err_q    <= q_err_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      lim_q      <= lim_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      d_integ_q  <= d_integ_d;
      q_integ_q  <= q_integ_d;
      d_volt_q   <= d_volt_d;
      q_volt_q   <= q_volt_d;
      valid_q    <= valid_d;
      for (int i = 0; i < 4; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign voltage_d_out        = d_volt_q;
  assign voltage_q_out        = q_volt_q;
  assign sin_out              = sin_q;
  assign cos_out              = cos_q;
  assign regulation_valid_out = valid_q;
  assign busy_out             = (state_q != IDLE);

endmodule

// File: tb/tb_current_pi_regulator.sv
// tb/tb_current_pi_regulator.sv - scoreboard bench for current_pi_regulator
// Driver pushes expected Vd/Vq/sin/cos per start; a negedge monitor checks timing and values.
module tb_current_pi_regulator;

  logic               sys_clk = 1'b0;
  logic               reset_n;
  logic               calc_enable_in;
  logic               integ_clear_in;
  logic signed [15:0] current_d_ref_in, current_q_ref_in, current_d_in, current_q_in;
  logic signed [15:0] sin_in, cos_in, kp_in, ki_in;
  logic        [15:0] output_limit_in;
  logic signed [15:0] voltage_d_out, voltage_q_out, sin_out, cos_out;
  logic               regulation_valid_out, busy_out;

  current_pi_regulator #(.DATA_WIDTH(16), .GAIN_FRAC(12)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .calc_enable_in(calc_enable_in), .integ_clear_in(integ_clear_in),
    .current_d_ref_in(current_d_ref_in), .current_q_ref_in(current_q_ref_in),
    .current_d_in(current_d_in), .current_q_in(current_q_in),
    .sin_in(sin_in), .cos_in(cos_in), .kp_in(kp_in), .ki_in(ki_in),
    .output_limit_in(output_limit_in),
    .voltage_d_out(voltage_d_out), .voltage_q_out(voltage_q_out),
    .sin_out(sin_out), .cos_out(cos_out),
    .regulation_valid_out(regulation_valid_out), .busy_out(busy_out)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int e0;
    int vd;
    int vq;
    int s;
    int c;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_integ_d = 0;
  int   m_integ_q = 0;

  function automatic int floor_div(input longint a);
    longint q;
    q = a / 4096;
    if ((a % 4096) != 0 && a < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int clampi(input longint x, input int l);
    if (x > l) return l;
    if (x < -l) return -l;
    return int'(x);
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic scramble_inputs();
    current_d_ref_in = 16'($urandom);
    current_q_ref_in = 16'($urandom);
    current_d_in     = 16'($urandom);
    current_q_in     = 16'($urandom);
    sin_in           = 16'($urandom);
    cos_in           = 16'($urandom);
    kp_in            = 16'($urandom);
    ki_in            = 16'($urandom);
    output_limit_in  = 16'($urandom);
  endtask

  always @(negedge sys_clk) begin
    logic ev, eb;
    int   d;
    ev = 1'b0;
    eb = 1'b0;
    if (reset_n) begin
      if (sbq.size() > 0) begin
        d  = cyc - sbq[0].e0;
        eb = (d >= 0 && d <= 5);
        ev = (d == 6);
        if (d == 5) begin
          check("vd_at_e5", int'(voltage_d_out), sbq[0].vd);
          check("vq_at_e5", int'(voltage_q_out), sbq[0].vq);
        end
      end
      check("valid", int'(regulation_valid_out), int'(ev));
      check("busy", int'(busy_out), int'(eb));
      if (ev) begin
        check("vd_at_valid", int'(voltage_d_out), sbq[0].vd);
        check("vq_at_valid", int'(voltage_q_out), sbq[0].vq);
        check("sin_at_valid", int'(sin_out), sbq[0].s);
        check("cos_at_valid", int'(cos_out), sbq[0].c);
        void'(sbq.pop_front());
      end
    end
  end

  // mode 0: normal, 1: integ_clear during MULT, 2: extra start while busy
  task automatic do_start(input int dref, input int dmeas, input int qref, input int qmeas,
                          input int kp, input int ki, input int lim, input int s, input int c,
                          input int mode, input int wait_n);
    exp_t e;
    int   l, ed, eq, k;
    l  = (lim > 32767) ? 32767 : lim;
    ed = dref - dmeas;
    eq = qref - qmeas;
    m_integ_d = clampi(longint'(m_integ_d) + floor_div(longint'(ed) * ki), l);
    m_integ_q = clampi(longint'(m_integ_q) + floor_div(longint'(eq) * ki), l);
    e.vd = clampi(longint'(floor_div(longint'(ed) * kp)) + m_integ_d, l);
    e.vq = clampi(longint'(floor_div(longint'(eq) * kp)) + m_integ_q, l);
    e.s  = s;
    e.c  = c;
    current_d_ref_in = 16'(dref);
    current_d_in     = 16'(dmeas);
    current_q_ref_in = 16'(qref);
    current_q_in     = 16'(qmeas);
    kp_in            = 16'(kp);
    ki_in            = 16'(ki);
    output_limit_in  = 16'(lim);
    sin_in           = 16'(s);
    cos_in           = 16'(c);
    calc_enable_in   = 1'b1;
    e.e0 = cyc + 1;
    sbq.push_back(e);
    @(posedge sys_clk);
    @(negedge sys_clk);
    k = 0;
    calc_enable_in = 1'b0;
    scramble_inputs();
    check("sin_latch", int'(sin_out), s);
    check("cos_latch", int'(cos_out), c);
    if (mode == 1) begin
      @(negedge sys_clk);
      k++;
      integ_clear_in = 1'b1;
      calc_enable_in = 1'b1;
      @(posedge sys_clk);
      void'(sbq.pop_back());
      m_integ_d = 0;
      m_integ_q = 0;
      @(negedge sys_clk);
      k++;
      integ_clear_in = 1'b0;
      calc_enable_in = 1'b0;
      check("abort_vd", int'(voltage_d_out), 0);
      check("abort_vq", int'(voltage_q_out), 0);
    end else if (mode == 2) begin
      repeat (3) @(negedge sys_clk);
      k += 3;
      calc_enable_in = 1'b1;
      @(negedge sys_clk);
      k++;
      calc_enable_in = 1'b0;
    end
    while (k < wait_n) begin
      @(negedge sys_clk);
      k++;
    end
  endtask

  task automatic do_clear();
    integ_clear_in = 1'b1;
    @(posedge sys_clk);
    m_integ_d = 0;
    m_integ_q = 0;
    @(negedge sys_clk);
    integ_clear_in = 1'b0;
    check("clear_vd", int'(voltage_d_out), 0);
    check("clear_vq", int'(voltage_q_out), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, lim, r;
    reset_n        = 1'b0;
    calc_enable_in = 1'b0;
    integ_clear_in = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge sys_clk);
    check("rst_vd", int'(voltage_d_out), 0);
    check("rst_vq", int'(voltage_q_out), 0);
    check("rst_sin", int'(sin_out), 0);
    check("rst_cos", int'(cos_out), 0);
    check("rst_valid", int'(regulation_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    reset_n = 1'b1;
    @(negedge sys_clk);

    do_start(1000, 400, 50, 50, 4096, 0, 32767, 16'h5A82, 16'h2000, 0, 6);
    check("tp_p_vd", int'(voltage_d_out), 600);
    check("tp_p_vq", int'(voltage_q_out), 0);

    do_clear();
    for (int i = 1; i <= 3; i++) begin
      do_start(100, 0, 0, 0, 0, 2048, 32767, 0, 0, 0, 6);
      check("tp_integ_vd", int'(voltage_d_out), 50 * i);
    end

    do_clear();
    do_start(0, 0, 20000, 0, 28672, 0, 30000, 1, 2, 0, 6);
    check("tp_sat_pos", int'(voltage_q_out), 30000);
    do_start(0, 0, 0, 20000, 28672, 0, 30000, 3, 4, 0, 6);
    check("tp_sat_neg", int'(voltage_q_out), -30000);

    do_clear();
    do_start(20000, 0, 0, 0, 0, 4096, 25000, 0, 0, 0, 6);
    do_start(20000, 0, 0, 0, 0, 4096, 25000, 0, 0, 0, 6);
    check("tp_windup_clamp", int'(voltage_d_out), 25000);
    do_start(0, 5000, 0, 0, 0, 4096, 25000, 0, 0, 0, 6);
    check("tp_windup_release", int'(voltage_d_out), 20000);

    do_clear();
    do_start(-1, 0, 0, 0, 2048, 0, 32767, 0, 0, 0, 6);
    check("tp_trunc_neg", int'(voltage_d_out), -1);
    do_start(1, 0, 0, 0, 2048, 0, 32767, 0, 0, 0, 6);
    check("tp_trunc_pos", int'(voltage_d_out), 0);

    do_start(500, 0, 500, 0, 4096, 4096, 32767, 16'h5A82, 16'h2000, 1, 6);
    do_start(300, 0, -300, 0, 4096, 0, 32767, 16'h5A82, 16'h2000, 2, 6);
    check("tp_busy_start_vd", int'(voltage_d_out), 300);

    do_start(12000, -9000, -7000, 3000, 9000, 5000, 0, 7, 8, 0, 6);
    check("tp_lim0_vd", int'(voltage_d_out), 0);
    check("tp_lim0_integ", m_integ_d, 0);
    do_start(30000, -30000, -30000, 30000, 32767, 32767, 16'hFFFF, 9, 10, 0, 6);
    check("tp_limsat_vd", int'(voltage_d_out), 32767);

    for (int n = 0; n < 200; n++) begin
      r    = $urandom_range(0, 19);
      mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      lim  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 2000);
      if ($urandom_range(0, 24) == 0) do_clear();
      do_start($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               lim, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
               mode, $urandom_range(6, 9));
    end

    do_start(1000, 0, 1000, 0, 4096, 0, 32767, 11, 12, 0, 2);
    #2;
    reset_n = 1'b0;
    sbq.delete();
    m_integ_d = 0;
    m_integ_q = 0;
    #1;
    check("midrst_busy", int'(busy_out), 0);
    check("midrst_sin", int'(sin_out), 0);
    check("midrst_vd", int'(voltage_d_out), 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/current_pi_regulator.md
# current_pi_regulator

Dual proportional-integral current regulator for the PMSM field-oriented control loop. It consumes the Id/Iq result and sin/cos angle forwarded by the Clark/Park stage, computes the d-axis and q-axis voltage commands, and forwards them with the angle to the inverse-Park stage. A single shared multiplier is time-multiplexed over four products per update, and clamped integrators provide anti-windup.

## Interface
- DATA_WIDTH, 16, width of currents, voltages, gains and sin/cos (signed, two's complement).
- GAIN_FRAC, 12, fractional bits of kp_in/ki_in (gain = raw / 4096).
- sys_clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- calc_enable_in  in  1  single-cycle start; all data inputs are sampled in the same cycle.
- integ_clear_in  in  1  synchronous clear of integrators and outputs; highest priority.
- current_d_ref_in, current_q_ref_in  in  16  signed Id/Iq references.
- current_d_in, current_q_in  in  16  signed measured Id/Iq from Clark/Park.
- sin_in, cos_in  in  16  signed electrical-angle sin/cos from Clark/Park.
- kp_in, ki_in  in  16  signed gains, Q3.12.
- output_limit_in  in  16  unsigned magnitude limit L; values above 32767 are treated as 32767.
- voltage_d_out, voltage_q_out  out  16  signed Vd/Vq commands.
- sin_out, cos_out  out  16  angle values latched at start, for inverse Park.
- regulation_valid_out  out  1  one-cycle pulse; outputs updated.
- busy_out  out  1  high from the cycle after start until regulation_valid_out is issued.

## Operation
- FSM states: IDLE, MULT, ACC, DONE.
  - IDLE goes to MULT on calc_enable_in.
  - MULT lasts 4 cycles, counted by mult_cnt 0..3, then goes to ACC.
  - ACC goes to DONE.
  - DONE goes to IDLE.
- Start edge (IDLE and calc_enable_in):
  - Latch ref, meas, kp, ki, L, sin and cos.
  - Register err_d = ref_d - meas_d and err_q = ref_q - meas_q as 17-bit signed values. No overflow is possible.
- MULT step order, one 17x16 signed product per cycle, registered:
  - cnt0: err_d*kp
  - cnt1: err_d*ki
  - cnt2: err_q*kp
  - cnt3: err_q*ki
- Each product is arithmetic-shifted right by GAIN_FRAC, which truncates toward negative infinity, giving p_x and i_x.
- ACC step, per axis:
  - integ_x = clamp(integ_x + i_x, -L, +L), computed at full width before the clamp.
  - v_x = clamp(p_x + integ_x_new, -L, +L).
  - Integrators are 16-bit registers and persist across updates.
- DONE step: regulation_valid_out = 1 for exactly one cycle.
- calc_enable_in is ignored when the FSM is not IDLE. There is no queueing.
- integ_clear_in sampled high, in any state:
  - Integrators, voltage_d_out and voltage_q_out are set to 0.
  - FSM goes to IDLE and any in-flight update is aborted with no valid pulse.
  - If calc_enable_in is high in the same cycle, it is ignored.
- When L = 0, both outputs are 0 and both integrators stay at 0.
- sin_out and cos_out update at the start edge and hold until the next start.

## Timing
- Reset values: every output is 0, the integrators are 0 and the FSM is in IDLE.
- Let E0 be the edge that samples calc_enable_in.
  - Products are registered at E1 through E4.
  - voltage_d_out and voltage_q_out update at E5.
  - regulation_valid_out is high in the cycle following E6, for 1 cycle.
- Minimum start-to-start period is 7 cycles. A start is accepted in the first cycle regulation_valid_out is high, because the FSM is already IDLE.
- busy_out is high after E0 through E6, and low in the cycle where valid is high.
- voltage outputs and sin/cos outputs are stable whenever regulation_valid_out is high, and between updates.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

## Test plan
- kp=4096, ki=0, L=32767, d_ref=1000, d_meas=400 -> voltage_d_out=600 at E5, valid pulse at E6+1; q-axis with equal ref/meas -> 0.
- kp=0, ki=2048, L=32767, err_d=100, three starts -> voltage_d_out = 50, 100, 150.
- kp=28672, err_q=20000, L=30000 -> voltage_q_out=30000. Negating the error gives -30000.
- Integral windup: ki=4096, err=+20000, L=25000, two starts -> integ_d clamps to 25000. Then err=-5000 with ki=4096, kp=0 -> 20000 on the next start, with no windup lag.
- kp=2048, err_d=-1 -> voltage_d_out=-1, confirming truncation toward negative infinity. err_d=+1 -> 0.
- integ_clear_in pulsed during MULT -> no valid pulse and outputs/integrators are 0; a start pulsed while busy, 3 cycles after E0, is ignored; sin_in=0x5A82 and cos_in=0x2000 appear on sin_out/cos_out one cycle after E0.
